// File: rtl/cram_arb_pkg.sv
// cram_arb_pkg: shared types and widths for the cart-RAM access arbiter.
//   cram_state_e   arbiter FSM states
//   CRAM_ADDR_W    CRAM byte address width (128KB)
//   CRAM_BK_ADDR_W backup-port word address width
package cram_arb_pkg;
  localparam int CRAM_ADDR_W    = 17;
  localparam int CRAM_BK_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE, CPU, CPU_RDW, BK_LO, BK_LOW, BK_HI, BK_HIW
  } cram_state_e;
endpackage

// File: rtl/cram_req_edge.sv
// cram_req_edge: rising-edge detector with a sticky pending flag.
//   clk_sys, reset_n  clock, async active-low reset
//   level             request strobe (level)
//   block             discard an edge seen this cycle
//   clr               request serviced this cycle
//   rise              raw rising edge of level
//   req               request outstanding (pending, or accepted edge this cycle)
module cram_req_edge (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic level,
  input  logic block,
  input  logic clr,
  output logic rise,
  output logic req
);
  logic prev, pend;

  assign rise = level & ~prev;
  // A fresh edge is visible immediately so an idle arbiter serves it without a wait cycle.
  assign req  = pend | (rise & ~block);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      prev <= level;
      // clr covers an edge served in the same cycle it arrived, so it must not stick.
      if (clr)                pend <= 1'b0;
      else if (rise && !block) pend <= 1'b1;
    end
  end
endmodule

// File: rtl/cram_access_arbiter.sv
// cram_access_arbiter: shares one single-port 8-bit CRAM between the savestate
// engine (highest), CPU/mapper accesses, and the 16-bit save-file backup port.
//   clk_sys, reset_n                 clock, async active-low reset
//   cpu_rd/cpu_wr/cpu_wr_en/cpu_addr/cpu_di/cpu_do   CPU byte port (edge-triggered)
//   ss_active/ss_addr/ss_wr/ss_di/ss_do              savestate pass-through
//   bk_req/bk_we/bk_addr/bk_din/bk_dout/bk_ack       backup word port
//   ram_addr/ram_di/ram_we/ram_q                     CRAM macro (1-cycle read)
//   cram_dirty                        only with CRAM_DIRTY_FLAG_EN defined
// All ram_* outputs are registered from the next-state decode, so the state a
// request is in is also the cycle its address is on the RAM.
module cram_access_arbiter
  import cram_arb_pkg::*;
#(
  parameter int ADDR_W    = CRAM_ADDR_W,
  parameter int BK_ADDR_W = CRAM_BK_ADDR_W
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  input  logic                 cpu_wr_en,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [7:0]           cpu_di,
  output logic [7:0]           cpu_do,
  input  logic                 ss_active,
  input  logic [ADDR_W-1:0]    ss_addr,
  input  logic                 ss_wr,
  input  logic [7:0]           ss_di,
  output logic [7:0]           ss_do,
  input  logic                 bk_req,
  input  logic                 bk_we,
  input  logic [BK_ADDR_W-1:0] bk_addr,
  input  logic [15:0]          bk_din,
  output logic [15:0]          bk_dout,
  output logic                 bk_ack,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [7:0]           ram_di,
  output logic                 ram_we,
  input  logic [7:0]           ram_q
`ifdef CRAM_DIRTY_FLAG_EN
  ,output logic                cram_dirty
`endif
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        di;
    logic              we;
  } cmd_t;

  cram_state_e state, state_d;
  cmd_t        cmd_q, cmd_d;
  logic        lo_done, lo_done_d, cur_wr, cur_wr_d;
  logic        start_cpu, start_lo, start_hi;
  logic        clr_rd, clr_wr, rd_req, wr_req, wr_rise, rd_rise_unused, cpu_pend;
  logic [7:0]  lo_byte;
  logic [ADDR_W-1:0] bk_lo_addr, bk_hi_addr;

  assign bk_lo_addr = ADDR_W'({bk_addr, 1'b0});
  assign bk_hi_addr = ADDR_W'({bk_addr, 1'b1});

  // Write edge beats a simultaneous read edge; the read is discarded.
  cram_req_edge u_wr_edge (
    .clk_sys(clk_sys), .reset_n(reset_n), .level(cpu_wr), .block(ss_active),
    .clr(clr_wr), .rise(wr_rise), .req(wr_req)
  );
  cram_req_edge u_rd_edge (
    .clk_sys(clk_sys), .reset_n(reset_n), .level(cpu_rd), .block(ss_active | wr_rise),
    .clr(clr_rd), .rise(rd_rise_unused), .req(rd_req)
  );

  assign cpu_pend = wr_req | rd_req;

  always_comb begin
    state_d   = state;
    lo_done_d = lo_done;
    cur_wr_d  = cur_wr;
    cmd_d     = cmd_q;
    cmd_d.we  = 1'b0;
    start_cpu = 1'b0;
    start_lo  = 1'b0;
    start_hi  = 1'b0;
    clr_rd    = 1'b0;
    clr_wr    = 1'b0;
    if (ss_active) begin
      // Savestate owns the RAM; any backup word restarts from its low byte.
      state_d   = IDLE;
      lo_done_d = 1'b0;
      cmd_d     = '{addr: ss_addr, di: ss_di, we: ss_wr};
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_pend)               start_cpu = 1'b1;
          // bk_ack still high means the requester has not yet dropped bk_req for the last word.
          else if (bk_req && !bk_ack) begin
            if (lo_done) start_hi = 1'b1;
            else         start_lo = 1'b1;
          end else if (!bk_req)       lo_done_d = 1'b0;
        end
        CPU:     state_d = cur_wr ? IDLE : CPU_RDW;
        CPU_RDW: state_d = IDLE;
        BK_LO:   state_d = bk_req ? BK_LOW : IDLE;
        BK_LOW: begin
          if (!bk_req) state_d = IDLE;
          else begin
            // Low byte is done; a CPU access may slip in before the high byte.
            lo_done_d = 1'b1;
            if (cpu_pend) start_cpu = 1'b1;
            else          start_hi  = 1'b1;
          end
        end
        BK_HI: begin
          state_d = bk_req ? BK_HIW : IDLE;
          if (!bk_req) lo_done_d = 1'b0;
        end
        BK_HIW: begin
          state_d   = IDLE;
          lo_done_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
      if (start_cpu) begin
        state_d  = CPU;
        cur_wr_d = wr_req;
        clr_wr   = wr_req;
        clr_rd   = ~wr_req;
        cmd_d    = '{addr: cpu_addr, di: cpu_di, we: wr_req & cpu_wr_en};
      end
      if (start_lo) begin
        state_d = BK_LO;
        cmd_d   = '{addr: bk_lo_addr, di: bk_din[7:0], we: bk_we};
      end
      if (start_hi) begin
        state_d = BK_HI;
        cmd_d   = '{addr: bk_hi_addr, di: bk_din[15:8], we: bk_we};
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cmd_q   <= '0;
      lo_done <= 1'b0;
      cur_wr  <= 1'b0;
      lo_byte <= '0;
      cpu_do  <= '0;
      bk_dout <= '0;
      bk_ack  <= 1'b0;
    end else begin
      state   <= state_d;
      cmd_q   <= cmd_d;
      lo_done <= lo_done_d;
      cur_wr  <= cur_wr_d;
      bk_ack  <= 1'b0;
      if (state == CPU_RDW) cpu_do  <= ram_q;
      if (state == BK_LOW)  lo_byte <= ram_q;
      if (state == BK_HIW && bk_req && !ss_active) begin
        bk_ack <= 1'b1;
        if (!bk_we) bk_dout <= {ram_q, lo_byte};
      end
    end
  end

  assign ram_addr = cmd_q.addr;
  assign ram_di   = cmd_q.di;
  assign ram_we   = cmd_q.we;
  assign ss_do    = ss_active ? ram_q : 8'h00;

`ifdef CRAM_DIRTY_FLAG_EN
  // Clean again only after a read sweep from word 0 to the last word with no CPU write in between.
  logic sweep_clean, cpu_commit, bk_rd_ack;
  assign cpu_commit = (state == CPU) && cmd_q.we;
  assign bk_rd_ack  = (state == BK_HIW) && bk_req && !ss_active && !bk_we;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cram_dirty  <= 1'b0;
      sweep_clean <= 1'b0;
    end else begin
      if (bk_rd_ack && bk_addr == '0) sweep_clean <= 1'b1;
      if (bk_rd_ack && (&bk_addr) && sweep_clean) begin
        cram_dirty  <= 1'b0;
        sweep_clean <= 1'b0;
      end
      if (cpu_commit) begin
        cram_dirty  <= 1'b1;
        sweep_clean <= 1'b0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cram_access_arbiter.sv
module tb_cram_access_arbiter;
  logic        clk_sys, reset_n;
  logic        cpu_rd, cpu_wr, cpu_wr_en;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_di, cpu_do;
  logic        ss_active, ss_wr;
  logic [16:0] ss_addr;
  logic [7:0]  ss_di, ss_do;
  logic        bk_req, bk_we, bk_ack;
  logic [15:0] bk_addr, bk_din, bk_dout;
  logic [16:0] ram_addr;
  logic [7:0]  ram_di, ram_q;
  logic        ram_we;
`ifdef CRAM_DIRTY_FLAG_EN
  logic        cram_dirty;
`endif

  int n_chk = 0, n_fail = 0;
  int we_cnt = 0, ack_cnt = 0;
  logic [7:0] mem [0:131071];

  cram_access_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_di(cpu_di), .cpu_do(cpu_do),
    .ss_active(ss_active), .ss_addr(ss_addr), .ss_wr(ss_wr), .ss_di(ss_di), .ss_do(ss_do),
    .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_din(bk_din),
    .bk_dout(bk_dout), .bk_ack(bk_ack),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we), .ram_q(ram_q)
`ifdef CRAM_DIRTY_FLAG_EN
    ,.cram_dirty(cram_dirty)
`endif
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // CRAM macro model: synchronous read, one cycle latency.
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_di;
    ram_q <= mem[ram_addr];
  end

  always @(posedge clk_sys) begin
    if (ram_we) we_cnt++;
    if (bk_ack) ack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  // One-cycle-wide CPU strobe; returns in the cycle the access holds the RAM.
  task automatic cpu_acc(input logic wr, input logic [16:0] a, input logic [7:0] d, input logic en);
    cpu_addr = a; cpu_di = d; cpu_wr_en = en;
    if (wr) cpu_wr = 1'b1; else cpu_rd = 1'b1;
    tick;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  // Backup word; lat = cycles from grant (low byte address on RAM) to bk_ack.
  task automatic bk_word(input logic we, input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] q, output int lat);
    int n;
    bk_req = 1'b1; bk_we = we; bk_addr = a; bk_din = d;
    n = 0;
    while (ram_addr !== {a, 1'b0} && n < 30) begin tick; n++; end
    lat = 0;
    while (bk_ack !== 1'b1 && lat < 30) begin tick; lat++; end
    q = bk_dout;
    bk_req = 1'b0;
    tick;
  endtask

  initial begin
    logic [15:0] q;
    int lat, w0, a0, bad, n;
    logic [16:0] ss_a [6];
    logic        ss_w [6];
    ss_a = '{17'h200, 17'd10, 17'h200, 17'd10, 17'd10, 17'd10};
    ss_w = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset_n = 1'b0; cpu_rd = 0; cpu_wr = 0; cpu_wr_en = 0; cpu_addr = '0; cpu_di = '0;
    ss_active = 0; ss_addr = '0; ss_wr = 0; ss_di = '0;
    bk_req = 0; bk_we = 0; bk_addr = '0; bk_din = '0;
    mem[17'h10] = 8'h77; mem[17'h122] = 8'h34;
    repeat (3) tick;
    chk("rst_cpu_do", cpu_do, 0);
    chk("rst_ss_do", ss_do, 0);
    chk("rst_bk_dout", bk_dout, 0);
    chk("rst_bk_ack", bk_ack, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_di", ram_di, 0);
    chk("rst_ram_we", ram_we, 0);
    reset_n = 1'b1;
    tick;

    // 1: write 0xA5 to 0x123, read it back two cycles after the RAM slot
    w0 = we_cnt;
    cpu_acc(1, 17'h123, 8'hA5, 1);
    tick; tick;
    chk("wr_we_pulses", we_cnt - w0, 1);
    chk("wr_mem", mem[17'h123], 8'hA5);
    cpu_acc(0, 17'h123, 8'h00, 1);
    tick;
    chk("rd_early", cpu_do, 8'h00);
    tick;
    chk("rd_data", cpu_do, 8'hA5);

    // 2: write with RAM disabled is dropped
    w0 = we_cnt;
    cpu_acc(1, 17'h10, 8'h5A, 0);
    tick; tick;
    chk("wp_no_we", we_cnt - w0, 0);
    cpu_acc(0, 17'h10, 8'h00, 1);
    tick; tick;
    chk("wp_old_byte", cpu_do, 8'h77);

    // 3: backup read of word 0x91 = bytes 0x122/0x123
    mem[17'h123] = 8'h12;
    a0 = ack_cnt;
    bk_word(0, 16'h0091, 16'h0, q, lat);
    chk("bk_rd_word", q, 16'h1234);
    chk("bk_rd_lat", lat, 4);
    chk("bk_ack_low", bk_ack, 0);
    tick; tick;
    chk("bk_rd_acks", ack_cnt - a0, 1);

    // 4: CPU read of 0x122 lands during BK_LOW of a write of 0xBEEF to word 5
    a0 = ack_cnt; w0 = we_cnt;
    bk_req = 1; bk_we = 1; bk_addr = 16'd5; bk_din = 16'hBEEF;
    n = 0;
    while (ram_addr !== 17'd10 && n < 30) begin tick; n++; end
    tick;
    cpu_rd = 1; cpu_addr = 17'h122;
    tick;
    cpu_rd = 0;
    tick; tick;
    chk("pre_cpu_data", cpu_do, 8'h34);
    chk("pre_cpu_first", ack_cnt - a0, 0);
    lat = 0;
    while (bk_ack !== 1'b1 && lat < 30) begin tick; lat++; end
    chk("pre_hi_lat", lat, 3);
    bk_req = 0;
    repeat (3) tick;
    chk("pre_acks", ack_cnt - a0, 1);
    chk("pre_we_pulses", we_cnt - w0, 2);
    chk("pre_lo_byte", mem[17'd10], 8'hEF);
    chk("pre_hi_byte", mem[17'd11], 8'hBE);

    // 5: savestate owns the RAM with a backup and a CPU edge pending
    a0 = ack_cnt; w0 = we_cnt; bad = 0;
    ss_active = 1; bk_req = 1; bk_we = 0; bk_addr = 16'h0091;
    for (int i = 0; i < 6; i++) begin
      ss_addr = ss_a[i]; ss_wr = ss_w[i]; ss_di = 8'h66;
      if (i == 1) begin cpu_rd = 1; cpu_addr = 17'h10; end
      tick;
      if (ram_addr !== ss_a[i]) bad++;
      if (i == 2) chk("ss_rd_ef", ss_do, 8'hEF);
      if (i == 3) chk("ss_rd_written", ss_do, 8'h66);
    end
    ss_active = 0; ss_wr = 0;
    chk("ss_owns_ram", bad, 0);
    chk("ss_we_pulses", we_cnt - w0, 1);
    chk("ss_mem", mem[17'h200], 8'h66);
    chk("ss_no_ack", ack_cnt - a0, 0);
    bk_word(0, 16'h0091, 16'h0, q, lat);
    chk("ss_bk_restart_lat", lat, 4);
    chk("ss_bk_word", q, 16'h1234);
    cpu_rd = 0;
    tick; tick;
    chk("ss_cpu_dropped", cpu_do, 8'h34);

`ifdef CRAM_DIRTY_FLAG_EN
    // 6: dirty tracking
    cpu_acc(1, 17'h300, 8'h11, 1);
    tick; tick;
    chk("dirty_set", cram_dirty, 1);
    bk_word(0, 16'h0000, 16'h0, q, lat);
    cpu_acc(1, 17'h301, 8'h22, 1);
    tick; tick;
    bk_word(0, 16'hFFFF, 16'h0, q, lat);
    chk("dirty_mid_write", cram_dirty, 1);
    bk_word(0, 16'h0000, 16'h0, q, lat);
    bk_word(0, 16'hFFFF, 16'h0, q, lat);
    chk("dirty_clear", cram_dirty, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
